// File: rtl/core_inst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_inst_pkg : sizes, instruction-word field positions and FSM encodings   |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
package core_inst_pkg;

  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int IN_W     = 6;
  localparam int K_W      = 3;
  localparam int OUT_W    = 4;
  localparam int ADDR_BW  = 11;
  localparam int INST_W   = 47;

  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K_W * K_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;

  localparam int CNT_W    = 6;
  localparam int KIJ_W    = 4;
  localparam int KW_BITS  = $clog2(K_W);
  localparam int OW_BITS  = $clog2(OUT_W);

  localparam int B_CEN_X    = 46;
  localparam int B_WEN_X    = 45;
  localparam int B_AX_LO    = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_W    = 19;
  localparam int B_WEN_W    = 18;
  localparam int B_AW_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // All memories deselected with write-enable inactive, every strobe low.
  localparam logic [INST_W-1:0] INST_IDLE = 47'h6001_800C_0000;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WLOAD   = 4'd1,
    ST_WPROP   = 4'd2,
    ST_GAP     = 4'd3,
    ST_EXEC    = 4'd4,
    ST_FLUSH   = 4'd5,
    ST_DRAIN   = 4'd6,
    ST_ACC_RD  = 4'd7,
    ST_ACC_END = 4'd8,
    ST_DONE    = 4'd9
  } state_t;

endpackage
`default_nettype wire

// File: rtl/acc_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_addr_gen : psum read address generator for the accumulation sweep       |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module acc_addr_gen
  import core_inst_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   j,
  input  logic               step_k,
  input  logic               step_o,
  output logic [ADDR_BW-1:0] a_pmem,
  output logic               last_j,
  output logic               last_o
);

  logic [KW_BITS-1:0] r_kx;
  logic [KW_BITS-1:0] r_ky;
  logic [OW_BITS-1:0] r_ox;
  logic [OW_BITS-1:0] r_oy;

  // Nine kernel steps wrap kx/ky back to zero, ready for the next output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kx <= '0;
      r_ky <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else begin
      if (step_k) begin
        if (r_kx == KW_BITS'(K_W - 1)) begin
          r_kx <= '0;
          r_ky <= (r_ky == KW_BITS'(K_W - 1)) ? '0 : r_ky + KW_BITS'(1);
        end else begin
          r_kx <= r_kx + KW_BITS'(1);
        end
      end
      if (step_o) begin
        if (r_ox == OW_BITS'(OUT_W - 1)) begin
          r_ox <= '0;
          r_oy <= (r_oy == OW_BITS'(OUT_W - 1)) ? '0 : r_oy + OW_BITS'(1);
        end else begin
          r_ox <= r_ox + OW_BITS'(1);
        end
      end
    end
  end

  assign a_pmem = ADDR_BW'(j) * ADDR_BW'(LEN_NIJ)
                + (ADDR_BW'(r_oy) + ADDR_BW'(r_ky)) * ADDR_BW'(IN_W)
                + ADDR_BW'(r_ox) + ADDR_BW'(r_kx);

  assign last_j = (j == CNT_W'(LEN_KIJ));
  assign last_o = (r_ox == OW_BITS'(OUT_W - 1)) && (r_oy == OW_BITS'(OUT_W - 1));

endmodule
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_sequencer : drives core.inst through a full 3x3 conv and acc sweep     |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module inst_sequencer
  import core_inst_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              acc_out_valid,
  output logic              busy,
  output logic              done
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [KIJ_W-1:0]   r_kij;
  logic [KIJ_W-1:0]   w_kij_next;
  logic [CNT_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]   w_wcnt_next;
  logic [INST_W-1:0]  r_inst;
  logic [INST_W-1:0]  w_inst_next;
  logic               r_busy;
  logic               w_busy_next;
  logic               r_done;
  logic               w_done_next;
  logic               r_acc_valid;
  logic               w_acc_valid_next;

  logic [ADDR_BW-1:0] w_acc_addr;
  logic               w_last_j;
  logic               w_last_o;
  logic               w_step_k;
  logic               w_step_o;

  assign w_step_k = (r_state == ST_ACC_RD) && !w_last_j;
  assign w_step_o = (r_state == ST_ACC_END);

  acc_addr_gen u_acc_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .j      (r_cnt),
    .step_k (w_step_k),
    .step_o (w_step_o),
    .a_pmem (w_acc_addr),
    .last_j (w_last_j),
    .last_o (w_last_o)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_kij       <= '0;
      r_wcnt      <= '0;
      r_inst      <= INST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_kij       <= w_kij_next;
      r_wcnt      <= w_wcnt_next;
      r_inst      <= w_inst_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_acc_valid <= w_acc_valid_next;
    end
  end

  // The word is built from the current state and registered, so consumer
  // strobes naturally trail their SRAM reads by the one-cycle read latency.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_kij_next       = r_kij;
    w_wcnt_next      = r_wcnt;
    w_inst_next      = INST_IDLE;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_acc_valid_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_WLOAD;
          w_cnt_next   = '0;
          w_kij_next   = '0;
          w_wcnt_next  = '0;
          w_busy_next  = 1'b1;
        end
      end
      ST_WLOAD: begin
        if (r_cnt < CNT_W'(COL)) begin
          w_inst_next[B_CEN_W]               = 1'b0;
          w_inst_next[B_AW_LO +: ADDR_BW]    = ADDR_BW'(r_kij) * ADDR_BW'(COL) + ADDR_BW'(r_cnt);
        end
        if (r_cnt != '0) w_inst_next[B_IFIFO_WR] = 1'b1;
        if (r_cnt == CNT_W'(COL)) begin
          w_state_next = ST_WPROP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_WPROP: begin
        w_inst_next[B_IFIFO_RD] = 1'b1;
        w_inst_next[B_LOAD]     = 1'b1;
        if (r_cnt == CNT_W'(ROW + COL - 2)) begin
          w_state_next = ST_GAP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_W'(3)) begin
          w_state_next = ST_EXEC;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (r_cnt < CNT_W'(LEN_NIJ)) begin
          w_inst_next[B_CEN_X]            = 1'b0;
          w_inst_next[B_AX_LO +: ADDR_BW] = ADDR_BW'(r_cnt);
        end
        if (r_cnt != '0) begin
          w_inst_next[B_L0_WR] = 1'b1;
          w_inst_next[B_L0_RD] = 1'b1;
          w_inst_next[B_EXEC]  = 1'b1;
        end
        if (r_cnt == CNT_W'(LEN_NIJ)) begin
          w_state_next = ST_FLUSH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        w_inst_next[B_L0_RD] = 1'b1;
        w_inst_next[B_EXEC]  = 1'b1;
        if (r_cnt == CNT_W'(ROW + COL - 1)) begin
          w_state_next = ST_DRAIN;
          w_cnt_next   = '0;
          w_wcnt_next  = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ofifo_valid) begin
          w_inst_next[B_OFIFO_RD]         = 1'b1;
          w_inst_next[B_CEN_P]            = 1'b0;
          w_inst_next[B_WEN_P]            = 1'b0;
          w_inst_next[B_AP_LO +: ADDR_BW] = ADDR_BW'(r_kij) * ADDR_BW'(LEN_NIJ) + ADDR_BW'(r_wcnt);
          if (r_wcnt == CNT_W'(LEN_NIJ - 1)) begin
            w_wcnt_next = '0;
            w_cnt_next  = '0;
            if (r_kij == KIJ_W'(LEN_KIJ - 1)) begin
              w_state_next = ST_ACC_RD;
            end else begin
              w_state_next = ST_WLOAD;
              w_kij_next   = r_kij + KIJ_W'(1);
            end
          end else begin
            w_wcnt_next = r_wcnt + CNT_W'(1);
          end
        end
      end
      ST_ACC_RD: begin
        if (!w_last_j) begin
          w_inst_next[B_CEN_P]            = 1'b0;
          w_inst_next[B_AP_LO +: ADDR_BW] = w_acc_addr;
        end
        if (r_cnt != '0) w_inst_next[B_ACC] = 1'b1;
        if (w_last_j) begin
          w_state_next = ST_ACC_END;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_ACC_END: begin
        w_acc_valid_next = 1'b1;
        w_state_next     = w_last_o ? ST_DONE : ST_ACC_RD;
      end
      ST_DONE: begin
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign inst          = r_inst;
  assign busy          = r_busy;
  assign done          = r_done;
  assign acc_out_valid = r_acc_valid;

endmodule
`default_nettype wire
